// File: rtl/ccff_bitstream_loader.sv
// Serialises host configuration words into a ccff chain, MSB first, while
// assembling the bits that fall out of the chain tail into readback words.
//
// state | meaning
// IDLE  | waiting for start after reset
// LOAD  | s_ready high, waiting for the next configuration word
// SHIFT | one chain bit per cycle from the word register
// DONE  | all CHAIN_LEN bits shifted; waiting for start
module ccff_bitstream_loader #(
  parameter int DATA_W    = 8,
  parameter int CHAIN_LEN = 50
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int BCW = $clog2(CHAIN_LEN + 1);
  localparam int CW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PW  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] rb_sr;
  logic [DATA_W-1:0] rb_next;
  logic [BCW-1:0]    bit_cnt;
  logic [CW-1:0]     sh_left;
  logic [PW-1:0]     pad;
  logic              last_bit;
  int                word_len;

  // Bits this word contributes: a full word, or whatever remains of the chain.
  always_comb begin
    word_len = CHAIN_LEN - int'(bit_cnt);
    if (word_len > DATA_W) word_len = DATA_W;
  end

  assign last_bit = (bit_cnt == BCW'(CHAIN_LEN - 1));
  assign rb_next  = {rb_sr[DATA_W-2:0], ccff_tail};

  always_ff @(posedge prog_clk) begin
    if (!pReset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start)   state_nx = LOAD;
      LOAD:       if (s_valid) state_nx = SHIFT;
      SHIFT:      if (sh_left == '0) state_nx = last_bit ? DONE : LOAD;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      sreg     <= '0;
      rb_sr    <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
      bit_cnt  <= '0;
      sh_left  <= '0;
      pad      <= '0;
    end else begin
      rb_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            bit_cnt <= '0;
            rb_sr   <= '0;
            rb_data <= '0;
          end
        end
        LOAD: begin
          if (s_valid) begin
            sreg    <= s_data;
            sh_left <= CW'(word_len - 1);
            pad     <= PW'(DATA_W - word_len);
          end
        end
        SHIFT: begin
          sreg    <= {sreg[DATA_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + BCW'(1);
          rb_sr   <= rb_next;
          if (sh_left == '0) begin
            // A short final word is left-aligned; the shift drops stale bits.
            rb_data  <= rb_next << pad;
            rb_valid <= 1'b1;
          end else begin
            sh_left <= sh_left - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready       = (state == LOAD);
  assign ccff_shift_en = (state == SHIFT);
  assign ccff_head     = ccff_shift_en & sreg[DATA_W-1];
  assign busy          = (state == LOAD) || (state == SHIFT);
  assign done          = (state == DONE);

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: drives loads into a behavioural chain model
// and checks bit order, timing and readback against a word/bit-level reference.
module tb_ccff_bitstream_loader;

  localparam int DW   = 8;
  localparam int CL   = 50;
  localparam int NW   = (CL + DW - 1) / DW;
  localparam int CL16 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          pReset, start, s_valid, s_ready;
  logic [DW-1:0] s_data, rb_data;
  logic          ccff_head, ccff_shift_en, ccff_tail, rb_valid, busy, done;

  logic          start16, s_valid16, s_ready16, head16, en16, rb_valid16, busy16, done16;
  logic [DW-1:0] s_data16, rb_data16;
  logic          tail16;

  ccff_bitstream_loader #(.DATA_W(DW), .CHAIN_LEN(CL)) dut (
    .prog_clk(clk), .pReset(pReset), .start(start), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .ccff_head(ccff_head),
    .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .rb_data(rb_data),
    .rb_valid(rb_valid), .busy(busy), .done(done)
  );

  ccff_bitstream_loader #(.DATA_W(DW), .CHAIN_LEN(CL16)) dut16 (
    .prog_clk(clk), .pReset(pReset), .start(start16), .s_data(s_data16),
    .s_valid(s_valid16), .s_ready(s_ready16), .ccff_head(head16),
    .ccff_shift_en(en16), .ccff_tail(tail16), .rb_data(rb_data16),
    .rb_valid(rb_valid16), .busy(busy16), .done(done16)
  );

  // Behavioural chain: CL flops, cleared by reset, advancing on shift enable.
  logic [CL-1:0] chain;
  always @(posedge clk) begin
    if (!pReset)            chain <= '0;
    else if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
  end
  assign ccff_tail = chain[CL-1];
  assign tail16    = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] cur_w [NW];
  bit            head_q[$];
  logic [DW-1:0] rb_q[$];
  int            runs_q[$];
  bit            prev_bits[$];
  int            shift_cnt, gap_cnt, cycles;

  function automatic bit exp_bit(int i);
    logic [DW-1:0] w;
    w = cur_w[i / DW];
    return w[DW-1-(i % DW)];
  endfunction

  function automatic int exp_run(int w);
    return (CL - w * DW < DW) ? CL - w * DW : DW;
  endfunction

  // Readback word w: the chain's old contents, oldest bit first, left-aligned.
  function automatic logic [DW-1:0] exp_rb(int w);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < DW; k++)
      if (w * DW + k < CL) v[DW-1-k] = prev_bits[w * DW + k];
    return v;
  endfunction

  function automatic int head_errs();
    int e;
    e = 0;
    if (head_q.size() != CL) return CL + 1;
    for (int i = 0; i < CL; i++) if (head_q[i] != exp_bit(i)) e++;
    return e;
  endfunction

  function automatic int runs_errs();
    int e;
    e = 0;
    if (runs_q.size() != NW) return NW + 1;
    for (int w = 0; w < NW; w++) if (runs_q[w] != exp_run(w)) e++;
    return e;
  endfunction

  function automatic int rb_errs();
    int e;
    e = 0;
    if (rb_q.size() != NW) return NW + 1;
    for (int w = 0; w < NW; w++) if (rb_q[w] !== exp_rb(w)) e++;
    return e;
  endfunction

  function automatic void commit_prev();
    prev_bits.delete();
    for (int i = 0; i < CL; i++) prev_bits.push_back(exp_bit(i));
  endfunction

  function automatic void clear_prev();
    prev_bits.delete();
    for (int i = 0; i < CL; i++) prev_bits.push_back(1'b0);
  endfunction

  function automatic void fixed_words();
    cur_w[0] = 8'hA5; cur_w[1] = 8'h3C; cur_w[2] = 8'hFF; cur_w[3] = 8'h00;
    cur_w[4] = 8'h81; cur_w[5] = 8'h7E; cur_w[6] = 8'hC0;
  endfunction

  function automatic void random_words();
    for (int i = 0; i < NW; i++) cur_w[i] = DW'($urandom);
  endfunction

  // Drives one load of cur_w and records what the DUT does, cycle by cycle.
  // gap_word/gap_len: hold s_valid low while offered that word.
  // start_at: pulse start after that many shifts. rst_at: reset there and return.
  task automatic run_load(input int gap_word, input int gap_len,
                          input int start_at, input int rst_at);
    int  idx, gap;
    bit  fin, prev_en;
    idx = 0; gap = gap_len; fin = 0; prev_en = 0;
    head_q.delete(); rb_q.delete(); runs_q.delete();
    shift_cnt = 0; gap_cnt = 0; cycles = 0;
    @(negedge clk);
    start = 1'b1; s_valid = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (ccff_shift_en) begin
        shift_cnt++;
        head_q.push_back(ccff_head);
        if (!prev_en) runs_q.push_back(1);
        else runs_q[runs_q.size()-1] = runs_q[runs_q.size()-1] + 1;
      end
      prev_en = ccff_shift_en;
      if (rb_valid) rb_q.push_back(rb_data);
      if (done) begin
        fin = 1;
      end else if (cycles > 400) begin
        checks++; failures++;
        $display("FAIL load_timeout cycles=%0d limit=400", cycles);
        fin = 1;
      end else if (ccff_shift_en && shift_cnt == rst_at) begin
        pReset = 1'b0; s_valid = 1'b0;
        fin = 1;
      end else begin
        if (ccff_shift_en && shift_cnt == start_at) start = 1'b1;
        if (s_ready) begin
          if (idx == gap_word && gap > 0) begin
            s_valid = 1'b0;
            gap--;
            if (!ccff_shift_en) gap_cnt++;
          end else begin
            s_valid = 1'b1;
            s_data  = cur_w[idx];
            if (idx < NW - 1) idx++;
          end
        end else begin
          s_valid = 1'b1;
          s_data  = cur_w[idx];
        end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    pReset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, ccff_head, ccff_shift_en, rb_valid, busy, done} !== 6'b0 || rb_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b rb=%h exp=000000 rb=00",
               {s_ready, ccff_head, ccff_shift_en, rb_valid, busy, done}, rb_data);
    end
    checks++;
    if ({s_ready16, en16, busy16, done16, rb_valid16} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs16 got=%b exp=00000", {s_ready16, en16, busy16, done16, rb_valid16});
    end
    pReset = 1'b1;
    @(negedge clk);
    clear_prev();
  endtask

  task automatic test_fixed();
    fixed_words();
    run_load(-1, 0, -1, -1);
    checks++;
    if (cycles !== 58) begin failures++; $display("FAIL fixed_done_cycle got=%0d exp=58", cycles); end
    checks++;
    if (shift_cnt !== CL) begin failures++; $display("FAIL fixed_shift_count got=%0d exp=%0d", shift_cnt, CL); end
    checks++;
    if (runs_errs() != 0) begin failures++; $display("FAIL fixed_runs got_errs=%0d exp=0 nruns=%0d", runs_errs(), runs_q.size()); end
    checks++;
    if (head_errs() != 0) begin failures++; $display("FAIL fixed_head_bits got_errs=%0d exp=0", head_errs()); end
    checks++;
    if (rb_errs() != 0) begin failures++; $display("FAIL fixed_rb_zero got_errs=%0d exp=0", rb_errs()); end
    repeat (3) @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b10) begin failures++; $display("FAIL done_held got=%b exp=10", {done, busy}); end
    commit_prev();
  endtask

  task automatic test_back_to_back();
    fixed_words();
    run_load(-1, 0, -1, -1);
    checks++;
    if (rb_errs() != 0) begin failures++; $display("FAIL b2b_rb_words got_errs=%0d exp=0", rb_errs()); end
    checks++;
    if (rb_q.size() != NW || rb_q[0] !== 8'hA5 || rb_q[NW-1] !== 8'hC0) begin
      failures++;
      $display("FAIL b2b_rb_ends n=%0d first=%h last=%h exp n=7 A5 C0", rb_q.size(),
               rb_q.size() > 0 ? rb_q[0] : 8'h0, rb_q.size() > 0 ? rb_q[rb_q.size()-1] : 8'h0);
    end
    checks++;
    if (head_errs() != 0) begin failures++; $display("FAIL b2b_head_bits got_errs=%0d exp=0", head_errs()); end
    commit_prev();
  endtask

  task automatic test_gap();
    fixed_words();
    run_load(3, 5, -1, -1);
    checks++;
    if (gap_cnt !== 5) begin failures++; $display("FAIL gap_ready_idle got=%0d exp=5", gap_cnt); end
    checks++;
    if (cycles !== 63) begin failures++; $display("FAIL gap_done_cycle got=%0d exp=63", cycles); end
    checks++;
    if (head_errs() != 0) begin failures++; $display("FAIL gap_head_bits got_errs=%0d exp=0", head_errs()); end
    checks++;
    if (rb_errs() != 0) begin failures++; $display("FAIL gap_rb_words got_errs=%0d exp=0", rb_errs()); end
    commit_prev();
  endtask

  task automatic test_start_ignored();
    random_words();
    run_load(-1, 0, 12, -1);
    checks++;
    if (cycles !== 58) begin failures++; $display("FAIL start_busy_cycle got=%0d exp=58", cycles); end
    checks++;
    if (shift_cnt !== CL) begin failures++; $display("FAIL start_busy_shifts got=%0d exp=%0d", shift_cnt, CL); end
    checks++;
    if (head_errs() != 0) begin failures++; $display("FAIL start_busy_head got_errs=%0d exp=0", head_errs()); end
    commit_prev();
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      int gw, gl;
      random_words();
      gw = $urandom_range(NW - 1, 0);
      gl = $urandom_range(4, 0);
      run_load(gw, gl, -1, -1);
      checks++;
      if (cycles !== 58 + gl) begin failures++; $display("FAIL rand%0d_cycle got=%0d exp=%0d", n, cycles, 58 + gl); end
      checks++;
      if (head_errs() != 0) begin failures++; $display("FAIL rand%0d_head got_errs=%0d exp=0", n, head_errs()); end
      checks++;
      if (rb_errs() != 0) begin failures++; $display("FAIL rand%0d_rb got_errs=%0d exp=0", n, rb_errs()); end
      commit_prev();
    end
  endtask

  task automatic test_reset_midload();
    int stray;
    random_words();
    run_load(-1, 0, -1, 20);
    checks++;
    if (shift_cnt !== 20) begin failures++; $display("FAIL abort_point got=%0d exp=20", shift_cnt); end
    @(negedge clk);
    pReset = 1'b1;
    checks++;
    if ({s_ready, ccff_head, ccff_shift_en, rb_valid, busy, done} !== 6'b0 || rb_data !== '0) begin
      failures++;
      $display("FAIL abort_outputs got=%b rb=%h exp=000000 rb=00",
               {s_ready, ccff_head, ccff_shift_en, rb_valid, busy, done}, rb_data);
    end
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (ccff_shift_en || rb_valid || busy) stray++;
    end
    checks++;
    if (stray !== 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", stray); end
    clear_prev();
    random_words();
    run_load(-1, 0, -1, -1);
    checks++;
    if (shift_cnt !== CL || cycles !== 58) begin
      failures++;
      $display("FAIL reload_after_abort shifts=%0d cycles=%0d exp=%0d 58", shift_cnt, cycles, CL);
    end
    checks++;
    if (head_errs() != 0) begin failures++; $display("FAIL reload_head got_errs=%0d exp=0", head_errs()); end
    checks++;
    if (rb_errs() != 0) begin failures++; $display("FAIL reload_rb got_errs=%0d exp=0", rb_errs()); end
    commit_prev();
  endtask

  task automatic test_short();
    logic [DW-1:0] w16[$];
    bit            h16[$];
    int            cyc, rbc, herr;
    bit            pending, fin;
    cyc = 0; rbc = 0; herr = 0; pending = 0; fin = 0;
    @(negedge clk);
    start16 = 1'b1; s_valid16 = 1'b1; s_data16 = DW'($urandom);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start16 = 1'b0;
      if (pending) begin s_data16 = DW'($urandom); pending = 0; end
      if (en16) h16.push_back(head16);
      if (rb_valid16) rbc++;
      if (s_ready16) begin w16.push_back(s_data16); pending = 1; end
      if (done16) fin = 1;
      else if (cyc > 200) begin
        checks++; failures++;
        $display("FAIL short_timeout cycles=%0d limit=200", cyc);
        fin = 1;
      end
    end
    s_valid16 = 1'b0;
    checks++;
    if (w16.size() != 2) begin failures++; $display("FAIL short_words got=%0d exp=2", w16.size()); end
    checks++;
    if (h16.size() != CL16) begin failures++; $display("FAIL short_shifts got=%0d exp=%0d", h16.size(), CL16); end
    checks++;
    if (rbc !== 2) begin failures++; $display("FAIL short_rb_pulses got=%0d exp=2", rbc); end
    checks++;
    if (cyc !== 1 + 2 + CL16) begin failures++; $display("FAIL short_done_cycle got=%0d exp=%0d", cyc, 1 + 2 + CL16); end
    if (w16.size() == 2 && h16.size() == CL16)
      for (int i = 0; i < CL16; i++) begin
        logic [DW-1:0] w;
        w = w16[i / DW];
        if (h16[i] != w[DW-1-(i % DW)]) herr++;
      end
    else herr = 1;
    checks++;
    if (herr !== 0) begin failures++; $display("FAIL short_head_bits got_errs=%0d exp=0", herr); end
  endtask

  initial begin
    pReset = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
    start16 = 1'b0; s_valid16 = 1'b0; s_data16 = '0;
    test_reset();
    test_fixed();
    test_back_to_back();
    test_gap();
    test_start_ignored();
    test_random();
    test_reset_midload();
    test_short();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
